// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_t;

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-wide storage for the responder: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module ahb_slv_mem #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_sys,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Commit one word per enabled edge.
    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_ws_slave.sv
// AHB-Lite word SRAM responder with programmable wait states.
// Optional build macro AHB_SLV_ERR_RESP_EN: illegal transfers get the
// two-cycle ERROR response; without it they complete as OKAY, writes are
// dropped and reads return zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no data phase pending, zero-wait OKAY
// WAIT    | data phase stalled, HREADYOUT low, down-counter running
// DONE    | data phase completes: write commits / read data driven
// ERR1    | first ERROR cycle, HREADYOUT low
// ERR2    | second ERROR cycle, HREADYOUT high
module ahb_ws_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int          MEM_DEPTH   = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int               IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [32:0]      ADDR_END = {1'b0, ADDR_BASE} + 33'(MEM_DEPTH) * 33'd4;
    localparam logic [3:0]       WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [IDX_W-1:0] BASE_IDX = ADDR_BASE[IDX_W+1:2];

    slv_state_t       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_in;
    logic             wr_q, legal_q;
    logic             accept, legal_in, mem_we;
    logic [31:0]      mem_rdata;

    // A stalled data phase never accepts, even if HREADY is mis-driven.
    assign accept   = HSEL & HREADY & HTRANS[1] & HREADYOUT;
    assign legal_in = (HADDR >= ADDR_BASE) && ({1'b0, HADDR} < ADDR_END) &&
                      (HADDR[1:0] == 2'b00) && (HSIZE == HSIZE_WORD);
    assign idx_in   = HADDR[IDX_W+1:2] - BASE_IDX;

    // Address-phase latch, loaded on every accepted transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            legal_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= idx_in;
            wr_q    <= HWRITE;
            legal_q <= legal_in;
        end
    end

    // State register and wait down-counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: WAIT runs to terminal count; IDLE/DONE/ERR2 are transfer boundaries.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
`ifdef AHB_SLV_ERR_RESP_EN
            ST_ERR1: state_nxt = ST_ERR2;
`endif
            default: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS_LOAD;
                    end else begin
                        state_nxt = ST_DONE;
                    end
`ifdef AHB_SLV_ERR_RESP_EN
                    if (!legal_in) begin
                        state_nxt = ST_ERR1;
                    end
`endif
                end
            end
        endcase
    end

    // Bus outputs decoded from state; read data only in a legal read DONE.
    always_comb begin
        HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
`ifdef AHB_SLV_ERR_RESP_EN
        HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
        HRESP     = HRESP_OKAY;
`endif
        mem_we    = (state == ST_DONE) && wr_q && legal_q;
        HRDATA    = ((state == ST_DONE) && !wr_q && legal_q) ? mem_rdata : 32'h0;
    end

    ahb_slv_mem #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_sys (HCLK),
        .we      (mem_we),
        .waddr   (idx_q),
        .wdata   (HWDATA),
        .raddr   (idx_q),
        .rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_ws_slave.sv
// Bench for ahb_ws_slave: two responders (1 and 0 wait states) on one
// shared address/data bus with separate selects, checked against a
// word-array reference model.
module tb_ahb_ws_slave;
    import ahb_pkg::*;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] END_A = BASE + 32'(DEPTH * 4);
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        HCLK, HRESETn;
    logic [1:0]  sel, rdy, rsp;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] rd [2];

    int n_chk = 0;
    int n_err = 0;
    int ws_of [2] = '{1, 0};
    logic [31:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    ahb_ws_slave #(.ADDR_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(1)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy[0]),
        .HREADYOUT(rdy[0]), .HRESP(rsp[0]), .HRDATA(rd[0]));

    ahb_ws_slave #(.ADDR_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(rdy[1]),
        .HREADYOUT(rdy[1]), .HRESP(rsp[1]), .HRDATA(rd[1]));

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; expectations come from the address rules and the model.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wd);
        bit   legal, err, done, resp_low;
        int   idx, waits, exp_waits;
        logic [31:0] off;
        legal = (addr >= BASE) && (addr < END_A) && (addr % 4 == 0) && (size == HSIZE_WORD);
        err   = !legal && ERR_EN;
        off   = addr - BASE;
        idx   = legal ? int'(off / 4) : 0;
        exp_waits = err ? 1 : ws_of[d];
        @(negedge HCLK);
        sel[d] = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(negedge HCLK);
        sel = 2'b00; HTRANS = HTRANS_IDLE; HWDATA = wd; HADDR = 32'h0; HWRITE = 1'b0;
        waits = 0; resp_low = 1'b0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (rdy[d]) begin
                done = 1'b1;
            end else begin
                waits++;
                resp_low |= rsp[d];
                @(negedge HCLK);
            end
        end
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
            return;
        end
        chk("waits", 32'(waits), 32'(exp_waits));
        chk("resp_stall", 32'(resp_low), 32'(err && exp_waits > 0));
        chk("resp_final", 32'(rsp[d]), 32'(err));
        if (!wr) begin
            if (!legal) chk("rdata_illegal", rd[d], 32'h0);
            else if (known[d][idx]) chk("rdata", rd[d], mdl[d][idx]);
        end else if (legal) begin
            mdl[d][idx]   = wd;
            known[d][idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          d;
        HRESETn = 1'b0; sel = 2'b00; HADDR = 32'h0; HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0; HSIZE = HSIZE_WORD; HWDATA = 32'h0;
        repeat (3) @(negedge HCLK);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(rdy[i]), 32'd1);
            chk("rst_resp", 32'(rsp[i]), 32'd0);
            chk("rst_rdata", rd[i], 32'h0);
        end
        HRESETn = 1'b1;

        // one wait state write then read
        xfer(0, 1'b1, BASE, HSIZE_WORD, 32'hAAAA_BBBB);
        xfer(0, 1'b0, BASE, HSIZE_WORD, 32'h0);

        // zero-wait back-to-back write then read of the same word
        @(negedge HCLK);
        sel[1] = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = BASE + 32'd4; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(negedge HCLK);
        chk("b2b_w_ready", 32'(rdy[1]), 32'd1);
        HWDATA = 32'h5555_5555; HWRITE = 1'b0;
        @(negedge HCLK);
        chk("b2b_r_ready", 32'(rdy[1]), 32'd1);
        chk("b2b_r_resp", 32'(rsp[1]), 32'd0);
        chk("b2b_rdata", rd[1], 32'h5555_5555);
        sel = 2'b00; HTRANS = HTRANS_IDLE;
        mdl[1][1] = 32'h5555_5555; known[1][1] = 1'b1;

        // out-of-window write, memory untouched
        xfer(0, 1'b1, 32'hFFDF_FDFF, HSIZE_WORD, 32'h1357_9BDF);
        xfer(1, 1'b1, 32'hFFDF_FDFF, HSIZE_WORD, 32'h1357_9BDF);
        xfer(0, 1'b0, BASE, HSIZE_WORD, 32'h0);

        // IDLE transfer with write qualifiers must not commit
        @(negedge HCLK);
        sel[0] = 1'b1; HTRANS = HTRANS_IDLE; HADDR = BASE; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(negedge HCLK);
        chk("idle_ready", 32'(rdy[0]), 32'd1);
        chk("idle_resp", 32'(rsp[0]), 32'd0);
        sel = 2'b00; HWDATA = 32'hFFFF_FFFF; HWRITE = 1'b0;
        xfer(0, 1'b0, BASE, HSIZE_WORD, 32'h0);

        // misaligned and byte-sized transfers
        xfer(0, 1'b1, BASE + 32'd2, HSIZE_WORD, 32'hDEAD_0001);
        xfer(0, 1'b1, BASE, 3'b000, 32'hDEAD_0002);
        xfer(1, 1'b1, BASE + 32'd6, HSIZE_WORD, 32'hDEAD_0003);
        xfer(0, 1'b0, BASE, HSIZE_WORD, 32'h0);
        xfer(1, 1'b0, BASE + 32'd4, HSIZE_WORD, 32'h0);

        // reset during the wait state of a write
        xfer(0, 1'b1, BASE + 32'd8, HSIZE_WORD, 32'h1234_5678);
        @(negedge HCLK);
        sel[0] = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = BASE + 32'd8; HWRITE = 1'b1; HSIZE = HSIZE_WORD;
        @(negedge HCLK);
        sel = 2'b00; HTRANS = HTRANS_IDLE; HWDATA = 32'hCAFE_F00D;
        chk("rstw_stalled", 32'(rdy[0]), 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk("rstw_ready", 32'(rdy[0]), 32'd1);
        chk("rstw_resp", 32'(rsp[0]), 32'd0);
        chk("rstw_rdata", rd[0], 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        xfer(0, 1'b0, BASE + 32'd8, HSIZE_WORD, 32'h0);

        // randomized mix against the model
        for (int n = 0; n < 120; n++) begin
            d  = int'($urandom_range(0, 1));
            sz = HSIZE_WORD;
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'd4;
                1:       a = END_A;
                2:       a = BASE + 32'($urandom_range(0, 15) * 4) + 32'd2;
                3: begin a = BASE + 32'($urandom_range(0, 15) * 4); sz = 3'($urandom_range(0, 7)); end
                4:       a = END_A - 32'd4;
                default: a = BASE + 32'($urandom_range(0, 15) * 4);
            endcase
            xfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
